vgacon_tty_ctrl: RTL and testbench
==================================

// Module: vgacon_tty_ctrl
// PURPOSE
//  Terminal-style write sequencer for the VGA console text buffer (NUM_ROWS x NUM_COLS bytes,
//  {color_sel, ascii[6:0]}). Consumes a byte stream, maintains a cursor, and issues buffer writes.
//  Handles CR/LF/BS/FF control codes, wraps at end of line, and scrolls on the last row.
//  Sits between the peripheral register decode (stream source) and the text buffer write port;
//  direct host writes to the buffer keep priority.
// PARAMETERS
//  NUM_ROWS   3      text rows
//  NUM_COLS   10     text columns
//  FILL_CHAR  8'h20  byte written by scroll (last row) and clear
// PORTS
//  clk         in   1   project clock
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   stream byte valid
//  in_data     in   8   stream byte: [7] color select, [6:0] code
//  in_ready    out  1   stream accept; transfer when in_valid & in_ready
//  host_busy   in   1   host is writing the buffer this cycle; controller write suppressed
//  buf_we      out  1   buffer write strobe
//  buf_waddr   out  5   buffer write address (row*NUM_COLS+col)
//  buf_wdata   out  8   buffer write data
//  buf_raddr   out  5   buffer read address (scroll source)
//  buf_rdata   in   8   buffer read data, combinational from buf_raddr
//  busy        out  1   state != IDLE
//  cur_row     out  2   cursor row
//  cur_col     out  4   cursor column
// BEHAVIOUR
//  - Reset: state IDLE, cur_row=0, cur_col=0, idx=0, buf_we=0, busy=0; buffer contents untouched.
//    Async reset mid-scroll/clear aborts immediately; partially moved rows stay as written.
//  - States: IDLE, PUT, SCROLL, CLEAR. in_ready = (state==IDLE) (see CONFIGURATION).
//  - Decode on accept cycle T (IDLE only):
//    0x20..0x7E -> latch byte, PUT at T+1.
//    0x0D CR    -> cur_col=0, stay IDLE.
//    0x0A LF    -> cur_col=0; row<NUM_ROWS-1: row++, stay IDLE; else SCROLL, idx=0.
//    0x08 BS    -> col>0: col--; col==0: no change. No write.
//    0x0C FF    -> CLEAR, idx=0.
//    any other  -> consumed, no effect.
//  - PUT: buf_we=~host_busy, waddr=cursor, wdata=latched byte. Held until a cycle with host_busy=0.
//    On the write: col<NUM_COLS-1 -> col++, IDLE; else col=0 and (row<last -> row++, IDLE;
//    row==last -> SCROLL, idx=0). Printable latency: write at T+1 when not stalled.
//  - SCROLL: idx 0..NUM_CHARS-1, one write per unstalled cycle. idx<NUM_CHARS-NUM_COLS:
//    raddr=idx+NUM_COLS, waddr=idx, wdata=buf_rdata; else wdata=FILL_CHAR. After last write:
//    cursor=(NUM_ROWS-1,0), IDLE. Unstalled duration NUM_CHARS cycles.
//  - CLEAR: waddr=idx, wdata=FILL_CHAR for all idx; after last write cursor=(0,0), IDLE.
//  - buf_we is combinational from state & ~host_busy; waddr/wdata/raddr derive from registers only.
//    idx and cursor advance only on cycles where buf_we=1. raddr=0 outside SCROLL.
//  - Host writes landing during SCROLL/CLEAR are not protected; may be overwritten or moved.
//  - Cursor never exceeds (NUM_ROWS-1, NUM_COLS-1); all address arithmetic fits 5 bits.
// CONFIGURATION
//  VGACON_TTY_FIFO_EN defined: 4-entry input FIFO in front of the decoder; in_ready = !fifo_full,
//    independent of state; decoder pops when IDLE; busy also high while FIFO non-empty.
//    Reset empties the FIFO.
//  Not defined: no FIFO; in_ready = (state==IDLE); a byte offered while busy waits (in_valid held).
// STRUCTURE
//  Shared package vgacon_pkg: state enum (IDLE/PUT/SCROLL/CLEAR), control code constants
//  (CHR_BS/CHR_LF/CHR_FF/CHR_CR), FILL_CHAR default, NUM_ROWS/NUM_COLS defaults.
//  One sub-module: vgacon_tty_fifo (4x8 sync FIFO, push/pop/full/empty), instantiated only
//  under VGACON_TTY_FIFO_EN.
// TESTING
//  1. Reset, send 'A'(0x41) then 0xC2 -> writes (addr0,0x41) at T+1, (addr1,0xC2); cursor (0,2).
//  2. Send 10 printables on row 0 -> 10th write addr 9, cursor (1,0); BS at col 0 -> no change.
//  3. Cursor (2,9), send 'Z' -> write addr 29, then SCROLL: 30 writes, addr k<20 gets old
//     byte k+10, addr 20..29 get 0x20; cursor (2,0); busy low after 31 cycles total.
//  4. host_busy held high 3 cycles during PUT/SCROLL -> buf_we low, idx/cursor frozen, then resume
//     with no skipped or duplicated address.
//  5. FF mid-screen -> 30 writes of 0x20 to addr 0..29, cursor (0,0); CR/LF/0x07 -> no writes.
//  6. Assert rst_n low at SCROLL idx 12 -> next cycle state IDLE, buf_we=0, cursor (0,0);
//     with VGACON_TTY_FIFO_EN, 4 bytes accepted back-to-back while busy, 5th stalls in_ready=0.

Source files
------------

// File: rtl/vgacon_pkg.sv
// Shared types and constants for the VGA console terminal controller.
// State encoding, control codes and default geometry.
package vgacon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PUT,
      SCROLL,
      CLEAR
   } tty_state_e;

   localparam logic [6:0] CHR_BS = 7'h08;
   localparam logic [6:0] CHR_LF = 7'h0A;
   localparam logic [6:0] CHR_FF = 7'h0C;
   localparam logic [6:0] CHR_CR = 7'h0D;

   localparam int         DEF_NUM_ROWS  = 3;
   localparam int         DEF_NUM_COLS  = 10;
   localparam logic [7:0] DEF_FILL_CHAR = 8'h20;

   function automatic logic is_print(input logic [6:0] c);
      return (c >= 7'h20) && (c <= 7'h7E);
   endfunction

endpackage

// File: rtl/vgacon_tty_fifo.sv
// 4x8 synchronous FIFO in front of the terminal decoder.
// Push while full and pop while empty are ignored.
module vgacon_tty_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       full_o,
   output logic       empty_o
);

   logic [7:0] mem_q [4];
   logic [1:0] wp_q, wp_d;
   logic [1:0] rp_q, rp_d;
   logic [2:0] cnt_q, cnt_d;
   logic       do_push, do_pop;

   assign full_o  = (cnt_q == 3'd4);
   assign empty_o = (cnt_q == 3'd0);
   assign data_o  = mem_q[rp_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // pointer and occupancy next-state
   always_comb begin
      wp_d  = do_push ? wp_q + 2'd1 : wp_q;
      rp_d  = do_pop ? rp_q + 2'd1 : rp_q;
      cnt_d = cnt_q;
      if (do_push && !do_pop) cnt_d = cnt_q + 3'd1;
      if (do_pop && !do_push) cnt_d = cnt_q - 3'd1;
   end

   // pointers reset to empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // storage needs no reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= data_i;
   end

endmodule

// File: rtl/vgacon_tty_ctrl.sv
// Terminal write sequencer: byte stream to text buffer writes.
// Optional input FIFO enabled by VGACON_TTY_FIFO_EN.
module vgacon_tty_ctrl
   import vgacon_pkg::*;
#(
   parameter int         NUM_ROWS  = DEF_NUM_ROWS,
   parameter int         NUM_COLS  = DEF_NUM_COLS,
   parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       host_busy,
   output logic       buf_we,
   output logic [4:0] buf_waddr,
   output logic [7:0] buf_wdata,
   output logic [4:0] buf_raddr,
   input  logic [7:0] buf_rdata,
   output logic       busy,
   output logic [1:0] cur_row,
   output logic [3:0] cur_col
);

   localparam int         NUM_CHARS = NUM_ROWS * NUM_COLS;
   localparam logic [1:0] LAST_ROW  = 2'(NUM_ROWS - 1);
   localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);
   localparam logic [4:0] LAST_IDX  = 5'(NUM_CHARS - 1);
   localparam logic [4:0] MOVE_N    = 5'(NUM_CHARS - NUM_COLS);
   localparam logic [4:0] COLS5     = 5'(NUM_COLS);

   tty_state_e state_q, state_d;
   logic [1:0] row_q, row_d;
   logic [3:0] col_q, col_d;
   logic [4:0] idx_q, idx_d;
   logic [7:0] chr_q, chr_d;

   logic       dec_valid;
   logic       dec_take;
   logic [7:0] dec_data;
   logic [6:0] code;
   logic       fifo_busy;
   logic       wr_en;
   logic [4:0] cur_addr;

`ifdef VGACON_TTY_FIFO_EN
   logic fifo_full;
   logic fifo_empty;

   vgacon_tty_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (in_valid & ~fifo_full),
      .data_i  (in_data),
      .pop_i   (dec_take),
      .data_o  (dec_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign in_ready  = ~fifo_full;
   assign dec_valid = ~fifo_empty;
   assign fifo_busy = ~fifo_empty;
`else
   assign in_ready  = (state_q == IDLE);
   assign dec_valid = in_valid;
   assign dec_data  = in_data;
   assign fifo_busy = 1'b0;
`endif

   assign dec_take = dec_valid & (state_q == IDLE);
   assign code     = dec_data[6:0];
   assign wr_en    = (state_q != IDLE) & ~host_busy;
   assign cur_addr = 5'({3'b0, row_q}) * COLS5 + {1'b0, col_q};

   // state, cursor, index and latched byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         idx_q   <= '0;
         chr_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         idx_q   <= idx_d;
         chr_q   <= chr_d;
      end
   end

   // decode and sequencing; cursor/idx move only on a write
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      idx_d   = idx_q;
      chr_d   = chr_q;
      unique case (state_q)
         IDLE: begin
            if (dec_take) begin
               if (is_print(code)) begin
                  chr_d   = dec_data;
                  state_d = PUT;
               end else if (code == CHR_CR) begin
                  col_d = '0;
               end else if (code == CHR_LF) begin
                  col_d = '0;
                  if (row_q < LAST_ROW) begin
                     row_d = row_q + 2'd1;
                  end else begin
                     state_d = SCROLL;
                     idx_d   = '0;
                  end
               end else if (code == CHR_BS) begin
                  if (col_q != 4'd0) col_d = col_q - 4'd1;
               end else if (code == CHR_FF) begin
                  state_d = CLEAR;
                  idx_d   = '0;
               end
            end
         end
         PUT: begin
            if (wr_en) begin
               if (col_q < LAST_COL) begin
                  col_d   = col_q + 4'd1;
                  state_d = IDLE;
               end else begin
                  col_d = '0;
                  if (row_q < LAST_ROW) begin
                     row_d   = row_q + 2'd1;
                     state_d = IDLE;
                  end else begin
                     state_d = SCROLL;
                     idx_d   = '0;
                  end
               end
            end
         end
         SCROLL: begin
            if (wr_en) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  row_d   = LAST_ROW;
                  col_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         CLEAR: begin
            if (wr_en) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  row_d   = '0;
                  col_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
      endcase
   end

   // buffer port drive from registered state
   always_comb begin
      buf_waddr = '0;
      buf_wdata = '0;
      buf_raddr = '0;
      unique case (state_q)
         IDLE: begin
         end
         PUT: begin
            buf_waddr = cur_addr;
            buf_wdata = chr_q;
         end
         SCROLL: begin
            buf_waddr = idx_q;
            if (idx_q < MOVE_N) begin
               buf_raddr = idx_q + COLS5;
               buf_wdata = buf_rdata;
            end else begin
               buf_wdata = FILL_CHAR;
            end
         end
         CLEAR: begin
            buf_waddr = idx_q;
            buf_wdata = FILL_CHAR;
         end
      endcase
   end

   assign buf_we  = wr_en;
   assign busy    = (state_q != IDLE) | fifo_busy;
   assign cur_row = row_q;
   assign cur_col = col_q;

endmodule

// File: tb/tb_vgacon_tty_ctrl.sv
// Bench for vgacon_tty_ctrl: random streams vs a screen model.
// Holds the text buffer memory that the controller reads and writes.
module tb_vgacon_tty_ctrl;

`ifdef VGACON_TTY_FIFO_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       host_busy = 1'b0;
   logic       in_ready;
   logic       buf_we;
   logic [4:0] buf_waddr;
   logic [7:0] buf_wdata;
   logic [4:0] buf_raddr;
   logic [7:0] buf_rdata;
   logic       busy;
   logic [1:0] cur_row;
   logic [3:0] cur_col;

   logic [7:0] mem [0:29];
   logic [4:0] wa [0:255];
   int         wr_cnt = 0;

   logic [7:0] sc [0:29];
   int         mr = 0;
   int         mc = 0;

   int vectors = 0;
   int miscompares = 0;

   vgacon_tty_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .host_busy (host_busy),
      .buf_we    (buf_we),
      .buf_waddr (buf_waddr),
      .buf_wdata (buf_wdata),
      .buf_raddr (buf_raddr),
      .buf_rdata (buf_rdata),
      .busy      (busy),
      .cur_row   (cur_row),
      .cur_col   (cur_col)
   );

   always #5 clk = ~clk;

   assign buf_rdata = (buf_raddr < 5'd30) ? mem[buf_raddr] : 8'h00;

   always @(posedge clk) begin
      if (buf_we) begin
         if (buf_waddr < 5'd30) mem[buf_waddr] <= buf_wdata;
         wa[wr_cnt[7:0]] <= buf_waddr;
         wr_cnt <= wr_cnt + 1;
      end
   end

   // ---------------- reference model ----------------
   function automatic void m_scroll();
      for (int k = 0; k < 20; k++) sc[k] = sc[k+10];
      for (int k = 20; k < 30; k++) sc[k] = 8'h20;
   endfunction

   function automatic void m_apply(input logic [7:0] b);
      int c;
      c = int'(b[6:0]);
      if (c >= 32 && c <= 126) begin
         sc[mr*10+mc] = b;
         mc++;
         if (mc == 10) begin
            mc = 0;
            if (mr < 2) mr++;
            else m_scroll();
         end
      end else if (c == 13) begin
         mc = 0;
      end else if (c == 10) begin
         mc = 0;
         if (mr < 2) mr++;
         else m_scroll();
      end else if (c == 8) begin
         if (mc > 0) mc--;
      end else if (c == 12) begin
         for (int k = 0; k < 30; k++) sc[k] = 8'h20;
         mr = 0;
         mc = 0;
      end
   endfunction

   function automatic logic [7:0] rprint();
      logic [7:0] b;
      b[7]   = 1'($urandom_range(0, 1));
      b[6:0] = 7'($urandom_range(32, 126));
      return b;
   endfunction

   // ---------------- driver helpers ----------------
   task automatic send(input logic [7:0] b, input bit rand_hb);
      int n;
      n = 0;
      while (!in_ready && n < 500) begin
         if (rand_hb) host_busy = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         n++;
      end
      host_busy = 1'b0;
      if (n >= 500) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit rand_hb, output int cyc);
      cyc = 0;
      while (busy && cyc < 500) begin
         if (rand_hb) host_busy = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         cyc++;
      end
      host_busy = 1'b0;
      if (cyc >= 500) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: busy=%0b want 0", busy);
      end
   endtask

   task automatic check_screen(input string tag);
      for (int i = 0; i < 30; i++) begin
         vectors++;
         if (mem[i] !== sc[i]) begin
            miscompares++;
            $display("FAIL %s cell %0d: got %0h want %0h", tag, i, mem[i], sc[i]);
         end
      end
   endtask

   task automatic check_cursor(input string tag);
      vectors++;
      if (cur_row !== 2'(mr) || cur_col !== 4'(mc)) begin
         miscompares++;
         $display("FAIL %s cursor: got (%0d,%0d) want (%0d,%0d)",
                  tag, cur_row, cur_col, mr, mc);
      end
   endtask

   task automatic check_seq(input string tag, input int w0);
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < 30; k++)
         if (wa[8'(w0 + k)] !== 5'(k)) ok = 1'b0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s addr_seq: got non-sequential writes want 0..29", tag);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || buf_we !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: busy=%0b we=%0b rdy=%0b want 0 0 1", busy, buf_we, in_ready);
      end
      mr = 0;
      mc = 0;
      check_cursor("reset");
   endtask

   task automatic test_put_latency();
      int cyc;
      send(8'h41, 1'b0);
      repeat (LAT - 1) @(negedge clk);
      #1;
      vectors++;
      if (buf_we !== 1'b1 || buf_waddr !== 5'd0 || buf_wdata !== 8'h41) begin
         miscompares++;
         $display("FAIL put_latency: we=%0b addr=%0d data=%0h want 1 0 41",
                  buf_we, buf_waddr, buf_wdata);
      end
      m_apply(8'h41);
      wait_idle(1'b0, cyc);
      send(8'hC2, 1'b0);
      m_apply(8'hC2);
      wait_idle(1'b0, cyc);
      check_screen("put");
      check_cursor("put");
   endtask

   task automatic test_wrap();
      int cyc, w0;
      logic [7:0] b;
      send(8'h0C, 1'b0);
      m_apply(8'h0C);
      wait_idle(1'b0, cyc);
      w0 = wr_cnt;
      for (int i = 0; i < 10; i++) begin
         b = rprint();
         send(b, 1'b0);
         m_apply(b);
         wait_idle(1'b0, cyc);
      end
      vectors++;
      if (wa[8'(w0 + 9)] !== 5'd9) begin
         miscompares++;
         $display("FAIL wrap_addr: got %0d want 9", wa[8'(w0 + 9)]);
      end
      check_cursor("wrap");
      w0 = wr_cnt;
      send(8'h08, 1'b0);
      m_apply(8'h08);
      wait_idle(1'b0, cyc);
      vectors++;
      if (wr_cnt != w0) begin
         miscompares++;
         $display("FAIL bs_col0_writes: got %0d want 0", wr_cnt - w0);
      end
      check_cursor("bs_col0");
      check_screen("wrap");
   endtask

   task automatic test_scroll();
      int cyc, w0;
      logic [7:0] b;
      send(8'h0A, 1'b0);
      m_apply(8'h0A);
      wait_idle(1'b0, cyc);
      for (int i = 0; i < 9; i++) begin
         b = rprint();
         send(b, 1'b0);
         m_apply(b);
         wait_idle(1'b0, cyc);
      end
      check_cursor("pre_scroll");
      w0 = wr_cnt;
      send(8'h5A, 1'b0);
      m_apply(8'h5A);
      wait_idle(1'b0, cyc);
      vectors++;
      if (cyc != 30 + LAT) begin
         miscompares++;
         $display("FAIL scroll_cycles: got %0d want %0d", cyc, 30 + LAT);
      end
      vectors++;
      if (wr_cnt - w0 != 31 || wa[8'(w0)] !== 5'd29) begin
         miscompares++;
         $display("FAIL scroll_writes: got %0d first %0d want 31 first 29",
                  wr_cnt - w0, wa[8'(w0)]);
      end
      check_seq("scroll", w0 + 1);
      check_screen("scroll");
      check_cursor("scroll");
   endtask

   task automatic test_host_busy();
      int cyc, w0, wc;
      logic [7:0] b;
      w0 = wr_cnt;
      b = rprint();
      send(b, 1'b0);
      host_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (buf_we !== 1'b0 || cur_col !== 4'(mc) || wr_cnt != w0) begin
            miscompares++;
            $display("FAIL put_stall: we=%0b col=%0d writes=%0d want 0 %0d 0",
                     buf_we, cur_col, wr_cnt - w0, mc);
         end
         @(negedge clk);
      end
      host_busy = 1'b0;
      m_apply(b);
      wait_idle(1'b0, cyc);
      vectors++;
      if (wr_cnt - w0 != 1 || wa[8'(w0)] !== 5'd20) begin
         miscompares++;
         $display("FAIL put_resume: got %0d writes addr %0d want 1 addr 20",
                  wr_cnt - w0, wa[8'(w0)]);
      end
      check_cursor("put_resume");
      w0 = wr_cnt;
      send(8'h0A, 1'b0);
      m_apply(8'h0A);
      repeat (5) @(negedge clk);
      host_busy = 1'b1;
      wc = wr_cnt;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (buf_we !== 1'b0 || wr_cnt != wc) begin
            miscompares++;
            $display("FAIL scroll_stall: we=%0b writes=%0d want 0 %0d",
                     buf_we, wr_cnt, wc);
         end
         @(negedge clk);
      end
      host_busy = 1'b0;
      wait_idle(1'b0, cyc);
      vectors++;
      if (wr_cnt - w0 != 30) begin
         miscompares++;
         $display("FAIL scroll_stall_count: got %0d want 30", wr_cnt - w0);
      end
      check_seq("scroll_stall", w0);
      check_screen("scroll_stall");
      check_cursor("scroll_stall");
   endtask

   task automatic test_ff_ctrl();
      int cyc, w0;
      logic [7:0] b;
      for (int i = 0; i < 3; i++) begin
         b = rprint();
         send(b, 1'b0);
         m_apply(b);
         wait_idle(1'b0, cyc);
      end
      w0 = wr_cnt;
      send(8'h0C, 1'b0);
      m_apply(8'h0C);
      wait_idle(1'b0, cyc);
      vectors++;
      if (wr_cnt - w0 != 30) begin
         miscompares++;
         $display("FAIL ff_count: got %0d want 30", wr_cnt - w0);
      end
      check_seq("ff", w0);
      check_screen("ff");
      check_cursor("ff");
      w0 = wr_cnt;
      send(8'h0D, 1'b0);
      m_apply(8'h0D);
      send(8'h0A, 1'b0);
      m_apply(8'h0A);
      send(8'h07, 1'b0);
      m_apply(8'h07);
      wait_idle(1'b0, cyc);
      vectors++;
      if (wr_cnt != w0) begin
         miscompares++;
         $display("FAIL ctrl_writes: got %0d want 0", wr_cnt - w0);
      end
      check_cursor("ctrl");
   endtask

   task automatic test_random();
      int cyc;
      logic [7:0] b;
      logic [6:0] ctl [0:6];
      ctl[0] = 7'h08; ctl[1] = 7'h0A; ctl[2] = 7'h0C; ctl[3] = 7'h0D;
      ctl[4] = 7'h07; ctl[5] = 7'h7F; ctl[6] = 7'h00;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 7) begin
            b = rprint();
         end else begin
            b[7]   = 1'($urandom_range(0, 1));
            b[6:0] = ctl[$urandom_range(0, 6)];
            if (b[6:0] == 7'h0C && $urandom_range(0, 3) != 0) b[6:0] = 7'h0D;
         end
         send(b, 1'b1);
         m_apply(b);
         wait_idle(1'b1, cyc);
         check_cursor("random");
      end
      check_screen("random");
   endtask

   task automatic test_reset_mid_scroll();
      int cyc, w0, n;
      for (int i = 0; i < 2; i++) begin
         send(8'h0A, 1'b0);
         m_apply(8'h0A);
         wait_idle(1'b0, cyc);
      end
      w0 = wr_cnt;
      send(8'h0A, 1'b0);
      n = 0;
      while (wr_cnt - w0 < 12 && n < 100) begin
         @(negedge clk);
         n++;
      end
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 12; k++) sc[k] = sc[k+10];
      mr = 0;
      mc = 0;
      vectors++;
      if (n >= 100 || busy !== 1'b0 || buf_we !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_scroll: busy=%0b we=%0b writes=%0d want 0 0 12",
                  busy, buf_we, wr_cnt - w0);
      end
      check_cursor("reset_mid_scroll");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_screen("reset_mid_scroll");
   endtask

`ifdef VGACON_TTY_FIFO_EN
   task automatic test_fifo();
      int cyc;
      logic [7:0] b;
      send(8'h0C, 1'b0);
      m_apply(8'h0C);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         b = rprint();
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fifo_accept %0d: in_ready=%0b want 1", i, in_ready);
         end
         in_valid = 1'b1;
         in_data  = b;
         m_apply(b);
         @(negedge clk);
      end
      in_data = rprint();
      #1;
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL fifo_full: in_ready=%0b busy=%0b want 0 1", in_ready, busy);
      end
      in_valid = 1'b0;
      wait_idle(1'b0, cyc);
      check_screen("fifo");
      check_cursor("fifo");
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_put_latency();
      test_wrap();
      test_scroll();
      test_host_busy();
      test_ff_ctrl();
      test_random();
      test_reset_mid_scroll();
`ifdef VGACON_TTY_FIFO_EN
      test_fifo();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
